// File: rtl/stroke_sequencer.sv
// rtl/stroke_sequencer.sv - walks a glyph's stroke table and issues scaled, offset line segments
module stroke_sequencer #(
  parameter int COORD_W   = 8,
  parameter int IDX_W     = 5,
  parameter int MAX_SHIFT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [3:0]         glyph_sel,
  input  logic [1:0]         scale,
  input  logic [COORD_W-1:0] x_off,
  input  logic [COORD_W-1:0] y_off,
  input  logic               abort,
  output logic [3:0]         tbl_glyph,
  output logic [IDX_W-1:0]   tbl_idx,
  input  logic [COORD_W-1:0] tbl_sx,
  input  logic [COORD_W-1:0] tbl_sy,
  input  logic [COORD_W-1:0] tbl_ex,
  input  logic [COORD_W-1:0] tbl_ey,
  input  logic               tbl_pen,
  input  logic               tbl_last,
  output logic [COORD_W-1:0] seg_sx,
  output logic [COORD_W-1:0] seg_sy,
  output logic [COORD_W-1:0] seg_ex,
  output logic [COORD_W-1:0] seg_ey,
  output logic               seg_pen,
  output logic               seg_valid,
  input  logic               seg_ready,
  output logic               busy,
  output logic               done,
  output logic               err
);

  // Headroom for the largest shift plus the offset carry.
  localparam int AW = COORD_W + MAX_SHIFT + 1;
  localparam logic [1:0]       MAX_S   = 2'(MAX_SHIFT);
  localparam logic [IDX_W-1:0] IDX_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_FINISH} state_t;

  state_t             state_q, state_d;
  logic [3:0]         glyph_q, glyph_d;
  logic [1:0]         scale_q, scale_d;
  logic [COORD_W-1:0] xoff_q, xoff_d, yoff_q, yoff_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [COORD_W-1:0] sx_q, sx_d, sy_q, sy_d, ex_q, ex_d, ey_q, ey_d;
  logic               pen_q, pen_d, last_q, last_d;
  logic               valid_q, valid_d, busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic [AW-1:0]      wsx, wsy, wex, wey;
  logic               any_sat;

  function automatic logic [AW-1:0] xform(input logic [COORD_W-1:0] c,
                                          input logic [1:0]         sh,
                                          input logic [COORD_W-1:0] off);
    xform = (AW'(c) << sh) + AW'(off);
  endfunction

  function automatic logic [COORD_W-1:0] clip(input logic [AW-1:0] w);
    clip = (|w[AW-1:COORD_W]) ? '1 : w[COORD_W-1:0];
  endfunction

  function automatic logic over(input logic [AW-1:0] w);
    over = |w[AW-1:COORD_W];
  endfunction

  // The table is addressed by the latched glyph and the current index, so its
  // outputs are transformed combinationally and captured only in FETCH.
  assign wsx     = xform(tbl_sx, scale_q, xoff_q);
  assign wsy     = xform(tbl_sy, scale_q, yoff_q);
  assign wex     = xform(tbl_ex, scale_q, xoff_q);
  assign wey     = xform(tbl_ey, scale_q, yoff_q);
  assign any_sat = over(wsx) | over(wsy) | over(wex) | over(wey);

  // Next-state and next-output logic; every output is registered from here.
  always_comb begin
    state_d = state_q;
    glyph_d = glyph_q;
    scale_d = scale_q;
    xoff_d  = xoff_q;
    yoff_d  = yoff_q;
    idx_d   = idx_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    ex_d    = ex_q;
    ey_d    = ey_q;
    pen_d   = pen_q;
    last_d  = last_q;
    valid_d = valid_q;
    err_d   = err_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          glyph_d = glyph_sel;
          scale_d = (scale > MAX_S) ? MAX_S : scale;
          xoff_d  = x_off;
          yoff_d  = y_off;
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (abort) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = S_FINISH;
        end else begin
          sx_d    = clip(wsx);
          sy_d    = clip(wsy);
          ex_d    = clip(wex);
          ey_d    = clip(wey);
          pen_d   = tbl_pen;
          last_d  = tbl_last;
          valid_d = 1'b1;
          if (any_sat) err_d = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Abort wins over a simultaneous handshake; that segment is dropped.
        if (abort) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = S_FINISH;
        end else if (valid_q && seg_ready) begin
          valid_d = 1'b0;
          if (last_q || idx_q == IDX_MAX) begin
            if (!last_q) err_d = 1'b1;
            done_d  = 1'b1;
            state_d = S_FINISH;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // All state and outputs, cleared asynchronously so reset drops seg_valid at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      glyph_q <= '0;
      scale_q <= '0;
      xoff_q  <= '0;
      yoff_q  <= '0;
      idx_q   <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      ex_q    <= '0;
      ey_q    <= '0;
      pen_q   <= 1'b0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      glyph_q <= glyph_d;
      scale_q <= scale_d;
      xoff_q  <= xoff_d;
      yoff_q  <= yoff_d;
      idx_q   <= idx_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      ex_q    <= ex_d;
      ey_q    <= ey_d;
      pen_q   <= pen_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign tbl_glyph = glyph_q;
  assign tbl_idx   = idx_q;
  assign seg_sx    = sx_q;
  assign seg_sy    = sy_q;
  assign seg_ex    = ex_q;
  assign seg_ey    = ey_q;
  assign seg_pen   = pen_q;
  assign seg_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_stroke_sequencer.sv
// tb/tb_stroke_sequencer.sv - randomized self-checking bench for stroke_sequencer
module tb_stroke_sequencer;

  localparam int CW = 8;
  localparam int IW = 3;
  localparam int MS = 2;
  localparam int DEPTH = 1 << IW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    glyph_sel = '0;
  logic [1:0]    scale = '0;
  logic [CW-1:0] x_off = '0, y_off = '0;
  logic          abort = 1'b0;
  logic [3:0]    tbl_glyph;
  logic [IW-1:0] tbl_idx;
  logic [CW-1:0] tbl_sx, tbl_sy, tbl_ex, tbl_ey;
  logic          tbl_pen, tbl_last;
  logic [CW-1:0] seg_sx, seg_sy, seg_ex, seg_ey;
  logic          seg_pen, seg_valid;
  logic          seg_ready = 1'b0;
  logic          busy, done, err;

  int n_checks = 0;
  int n_fail   = 0;

  // Stroke table: per glyph, DEPTH strokes and the index of the last one (DEPTH = never).
  int tsx [16][DEPTH];
  int tsy [16][DEPTH];
  int tex [16][DEPTH];
  int tey [16][DEPTH];
  bit tpen[16][DEPTH];
  int tlast[16];

  typedef struct {
    int sx, sy, ex, ey;
    bit pen;
    bit sat;
  } seg_t;

  always #5 clk = ~clk;

  assign tbl_sx   = CW'(tsx[tbl_glyph][tbl_idx]);
  assign tbl_sy   = CW'(tsy[tbl_glyph][tbl_idx]);
  assign tbl_ex   = CW'(tex[tbl_glyph][tbl_idx]);
  assign tbl_ey   = CW'(tey[tbl_glyph][tbl_idx]);
  assign tbl_pen  = tpen[tbl_glyph][tbl_idx];
  assign tbl_last = (tlast[tbl_glyph] == int'(tbl_idx));

  stroke_sequencer #(.COORD_W(CW), .IDX_W(IW), .MAX_SHIFT(MS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .glyph_sel(glyph_sel), .scale(scale),
    .x_off(x_off), .y_off(y_off), .abort(abort), .tbl_glyph(tbl_glyph), .tbl_idx(tbl_idx),
    .tbl_sx(tbl_sx), .tbl_sy(tbl_sy), .tbl_ex(tbl_ex), .tbl_ey(tbl_ey),
    .tbl_pen(tbl_pen), .tbl_last(tbl_last),
    .seg_sx(seg_sx), .seg_sy(seg_sy), .seg_ex(seg_ex), .seg_ey(seg_ey),
    .seg_pen(seg_pen), .seg_valid(seg_valid), .seg_ready(seg_ready),
    .busy(busy), .done(done), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int xf(input int c, input int s, input int off, inout bit sat);
    int v;
    v = c * (1 << s) + off;
    if (v > (1 << CW) - 1) begin
      sat = 1'b1;
      v = (1 << CW) - 1;
    end
    return v;
  endfunction

  // ready_mode: 0 always ready, 1 random, 2 ready held low 5 cycles on segment 1.
  // abort_at / reset_at: segment number at which to abort / pulse reset (-1 = never).
  task automatic run_glyph(input int g, input int sc, input int xo, input int yo,
                           input int ready_mode, input int abort_at, input int reset_at,
                           input bit poke_start);
    seg_t exp_q[$];
    seg_t s;
    int   eff, n, cyc, low_cnt, lim;
    bit   overrun, aborted, finished, held, exp_err;

    eff = (sc > MS) ? MS : sc;
    overrun = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      s.sat = 1'b0;
      s.sx  = xf(tsx[g][i], eff, xo, s.sat);
      s.sy  = xf(tsy[g][i], eff, yo, s.sat);
      s.ex  = xf(tex[g][i], eff, xo, s.sat);
      s.ey  = xf(tey[g][i], eff, yo, s.sat);
      s.pen = tpen[g][i];
      exp_q.push_back(s);
      if (tlast[g] == i) break;
      if (i == DEPTH - 1) overrun = 1'b1;
    end
    if (abort_at >= exp_q.size()) abort_at = -1;

    @(negedge clk);
    glyph_sel = 4'(g); scale = 2'(sc); x_off = CW'(xo); y_off = CW'(yo);
    start = 1'b1; seg_ready = 1'b0; abort = 1'b0;
    @(negedge clk);
    start = 1'b0;
    glyph_sel = ~glyph_sel;
    check("fetch_busy", busy, 1);
    check("fetch_valid", seg_valid, 0);
    check("glyph_latch", tbl_glyph, g);
    check("err_cleared", err, 0);

    cyc = 1; n = 0; low_cnt = 0; aborted = 1'b0; finished = 1'b0; held = 1'b0;
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (held) check("hold_valid", seg_valid, 1);
      seg_ready = 1'b0; abort = 1'b0; start = 1'b0; held = 1'b0;
      if (done) begin
        finished = 1'b1;
        break;
      end
      if (poke_start && cyc == 5) start = 1'b1;
      if (seg_valid) begin
        if (n >= exp_q.size()) begin
          check("extra_seg", n, exp_q.size() - 1);
          break;
        end
        if (reset_at == n) begin
          #2 rst_n = 1'b0;
          #1;
          check("rst_valid", seg_valid, 0);
          check("rst_busy", busy, 0);
          check("rst_done", done, 0);
          check("rst_idx", tbl_idx, 0);
          #1 rst_n = 1'b1;
          for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_rst_done", done, 0);
            check("post_rst_busy", busy, 0);
          end
          return;
        end
        check("tbl_idx", tbl_idx, n);
        check("seg_sx", seg_sx, exp_q[n].sx);
        check("seg_sy", seg_sy, exp_q[n].sy);
        check("seg_ex", seg_ex, exp_q[n].ex);
        check("seg_ey", seg_ey, exp_q[n].ey);
        check("seg_pen", seg_pen, exp_q[n].pen);
        if (ready_mode == 0) check("spacing", cyc, 2 + 2 * n);
        case (ready_mode)
          0:       seg_ready = 1'b1;
          1:       seg_ready = ($urandom_range(0, 2) != 0);
          default: begin
            if (n == 1 && low_cnt < 5) begin
              seg_ready = 1'b0;
              low_cnt++;
            end else begin
              seg_ready = 1'b1;
            end
          end
        endcase
        if (n == abort_at) begin
          abort = 1'b1;
          seg_ready = 1'b1;
          aborted = 1'b1;
        end else if (seg_ready) begin
          n++;
        end else begin
          held = 1'b1;
        end
      end
    end

    seg_ready = 1'b0; abort = 1'b0; start = 1'b0;
    if (!finished) begin
      check("done_timeout", 0, 1);
      return;
    end
    lim = aborted ? abort_at : exp_q.size() - 1;
    exp_err = overrun && !aborted;
    for (int i = 0; i <= lim; i++) if (exp_q[i].sat) exp_err = 1'b1;
    check("done_valid", seg_valid, 0);
    check("done_busy", busy, 1);
    check("seg_count", n, aborted ? abort_at : exp_q.size());
    check("err_flag", err, exp_err);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("idle_busy", busy, 0);
    @(negedge clk);
    check("stay_idle", busy, 0);
    check("err_sticky", err, exp_err);
  endtask

  initial begin
    for (int g = 0; g < 16; g++) begin
      for (int i = 0; i < DEPTH; i++) begin
        tsx[g][i] = $urandom_range(0, 255);
        tsy[g][i] = $urandom_range(0, 255);
        tex[g][i] = $urandom_range(0, 255);
        tey[g][i] = $urandom_range(0, 255);
        tpen[g][i] = 1'($urandom_range(0, 1));
      end
      tlast[g] = $urandom_range(0, DEPTH);
    end
    tlast[0] = 6;
    tlast[1] = 0;
    tsx[1][0] = 60; tsy[1][0] = 40; tex[1][0] = 60; tey[1][0] = 120; tpen[1][0] = 1'b1;
    tlast[2] = DEPTH;

    #12;
    check("rst_state_valid", seg_valid, 0);
    check("rst_state_busy", busy, 0);
    check("rst_state_done", done, 0);
    check("rst_state_err", err, 0);
    check("rst_state_idx", tbl_idx, 0);
    check("rst_state_glyph", tbl_glyph, 0);
    check("rst_state_sx", seg_sx, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Abort in IDLE is ignored.
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("idle_abort", busy, 0);

    run_glyph(0, 0, 0, 0, 0, -1, -1, 1'b0);
    run_glyph(1, 1, 10, 5, 0, -1, -1, 1'b0);
    run_glyph(1, 2, 10, 5, 0, -1, -1, 1'b0);
    run_glyph(1, 3, 10, 5, 0, -1, -1, 1'b0);
    run_glyph(0, 1, 7, 3, 2, -1, -1, 1'b0);
    run_glyph(0, 0, 0, 0, 0, 2, -1, 1'b1);
    run_glyph(2, 0, 0, 0, 0, -1, -1, 1'b0);
    run_glyph(0, 0, 0, 0, 0, -1, 1, 1'b0);
    run_glyph(0, 0, 0, 0, 0, -1, -1, 1'b0);

    for (int t = 0; t < 30; t++) begin
      run_glyph($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 255),
                $urandom_range(0, 255), 1, $urandom_range(0, 12), -1, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
